// File: rtl/limb_pkg.sv
// Shared types for the memory access unit: bus trans encodings, FSM states and request payload.
package limb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TRANS_W = 2;
  localparam int unsigned PROT_W  = 2;

  localparam logic [TRANS_W-1:0] TRANS_I = 2'b00;
  localparam logic [TRANS_W-1:0] TRANS_C = 2'b01;
  localparam logic [TRANS_W-1:0] TRANS_N = 2'b10;
  localparam logic [TRANS_W-1:0] TRANS_S = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              size;
    logic              priv;
  } req_t;

endpackage

// File: rtl/memory_access_unit_if.sv
// Requester + memory bus bundle for memory_access_unit; slave = the unit, master = requester/memory side.
interface memory_access_unit_if;
  import limb_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_size;
  logic                req_priv;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_abort;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                abort;
  logic                write;
  logic                size;
  logic [PROT_W-1:0]   prot;
  logic [TRANS_W-1:0]  trans;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_priv, rdata, abort,
    output req_ready, rsp_valid, rsp_rdata, rsp_abort, addr, wdata, write, size, prot, trans
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_priv, rdata, abort,
    input  req_ready, rsp_valid, rsp_rdata, rsp_abort, addr, wdata, write, size, prot, trans
  );

endinterface

// File: rtl/memory_access_unit.sv
// Single-outstanding memory access unit: IDLE -> ADDR -> DATA, response two cycles after accept.
// Define MEMORY_ACCESS_SEQ_EN to mark back-to-back consecutive accesses as sequential (trans=11).
module memory_access_unit
  import limb_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_reset,
  memory_access_unit_if.slave  bus
);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_abort_q, rsp_abort_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                size_q, size_d;
  logic [PROT_W-1:0]   prot_q, prot_d;
  logic [TRANS_W-1:0]  trans_q, trans_d;
  logic                is_write_q, is_write_d;
  logic                seq_hit_c;
  req_t                req;

  assign req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata,
                 size: bus.req_size, priv: bus.req_priv};

`ifdef MEMORY_ACCESS_SEQ_EN
  logic hist_valid_q, hist_valid_d;

  // addr_q/is_write_q still describe the previous access while back in IDLE
  assign seq_hit_c = hist_valid_q && (req.write == is_write_q) &&
                     (req.addr == addr_q + ADDR_W'(1));
`else
  assign seq_hit_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_abort_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = 1'b0;
    size_d      = size_q;
    prot_d      = prot_q;
    trans_d     = TRANS_I;
    is_write_d  = is_write_q;
`ifdef MEMORY_ACCESS_SEQ_EN
    hist_valid_d = hist_valid_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef MEMORY_ACCESS_SEQ_EN
        hist_valid_d = 1'b0;
`endif
        if (bus.req_valid && req_ready_q) begin
          state_d     = ST_ADDR;
          req_ready_d = 1'b0;
          addr_d      = req.addr;
          wdata_d     = req.wdata;
          write_d     = req.write;
          is_write_d  = req.write;
          size_d      = req.size;
          prot_d      = {req.priv, 1'b1};
          trans_d     = seq_hit_c ? TRANS_S : TRANS_N;
        end
      end
      ST_ADDR: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_abort_d = bus.abort;
        rsp_rdata_d = (!is_write_q && !bus.abort) ? bus.rdata : '0;
`ifdef MEMORY_ACCESS_SEQ_EN
        hist_valid_d = !bus.abort;
`endif
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_abort_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      size_q      <= 1'b0;
      prot_q      <= '0;
      trans_q     <= TRANS_I;
      is_write_q  <= 1'b0;
`ifdef MEMORY_ACCESS_SEQ_EN
      hist_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_abort_q <= rsp_abort_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      size_q      <= size_d;
      prot_q      <= prot_d;
      trans_q     <= trans_d;
      is_write_q  <= is_write_d;
`ifdef MEMORY_ACCESS_SEQ_EN
      hist_valid_q <= hist_valid_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_abort = rsp_abort_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.write     = write_q;
  assign bus.size      = size_q;
  assign bus.prot      = prot_q;
  assign bus.trans     = trans_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed scenarios then random accesses against a
// reference memory and sequential-history model (follows MEMORY_ACCESS_SEQ_EN when defined).
module tb_memory_access_unit;

  logic clk;
  logic n_reset;
  int   n_cmp;
  int   n_err;

  logic [31:0] tb_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Reference sequential history: previous access eligible to be followed by a sequential one
  logic        ref_hv;
  logic [31:0] ref_ha;
  logic        ref_hw;

  memory_access_unit_if bus_if ();

  memory_access_unit dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic junk_req();
    bus_if.req_valid = 1'($urandom % 2);
    bus_if.req_write = 1'($urandom % 2);
    bus_if.req_addr  = $urandom;
    bus_if.req_wdata = $urandom;
    bus_if.req_size  = 1'($urandom % 2);
    bus_if.req_priv  = 1'($urandom % 2);
  endtask

  task automatic idle(input int n);
    bus_if.req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("idle_trans", 32'(bus_if.trans), 32'd0);
    end
    ref_hv = 1'b0;
  endtask

  // Called at posedge+1 with the unit in IDLE; returns at posedge+1 of the response cycle
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic priv, input logic sz, input logic ab);
    logic [1:0]  exp_trans;
    logic [31:0] exp_rd;
    exp_trans = 2'b10;
`ifdef MEMORY_ACCESS_SEQ_EN
    if (ref_hv && ref_hw == wr && a == ref_ha + 32'd1) exp_trans = 2'b11;
`endif
    chk("ready_idle", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
    bus_if.req_size  = sz;
    bus_if.req_priv  = priv;
    @(posedge clk); #1;
    junk_req();
    chk("addr_trans", 32'(bus_if.trans), 32'(exp_trans));
    chk("addr_write", 32'(bus_if.write), 32'(wr));
    chk("addr_addr", bus_if.addr, a);
    chk("addr_wdata", bus_if.wdata, d);
    chk("addr_size", 32'(bus_if.size), 32'(sz));
    chk("addr_prot", 32'(bus_if.prot), 32'({priv, 1'b1}));
    chk("addr_ready", 32'(bus_if.req_ready), 32'd0);
    chk("addr_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    if (bus_if.write && !ab) tb_mem[bus_if.addr] = bus_if.wdata;
    @(posedge clk); #1;
    junk_req();
    chk("data_trans", 32'(bus_if.trans), 32'd0);
    chk("data_write", 32'(bus_if.write), 32'd0);
    chk("data_addr", bus_if.addr, a);
    chk("data_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    bus_if.rdata = tb_mem.exists(bus_if.addr) ? tb_mem[bus_if.addr] : 32'h0;
    if (wr) bus_if.rdata = $urandom | 32'h1;
    bus_if.abort = ab;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    exp_rd = (wr || ab) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
    chk("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    chk("rsp_abort", 32'(bus_if.rsp_abort), 32'(ab));
    chk("rsp_rdata", bus_if.rsp_rdata, exp_rd);
    chk("rsp_ready", 32'(bus_if.req_ready), 32'd1);
    chk("rsp_trans", 32'(bus_if.trans), 32'd0);
    bus_if.rdata = $urandom;
    bus_if.abort = 1'b0;
    if (wr && !ab) ref_mem[a] = d;
    ref_hv = !ab;
    ref_ha = a;
    ref_hw = wr;
  endtask

  initial begin
    logic [31:0] prev_a;
    logic [31:0] ra;
    n_cmp   = 0;
    n_err   = 0;
    ref_hv  = 1'b0;
    ref_ha  = 32'h0;
    ref_hw  = 1'b0;
    n_reset = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 32'h0;
    bus_if.req_wdata = 32'h0;
    bus_if.req_size  = 1'b0;
    bus_if.req_priv  = 1'b0;
    bus_if.rdata     = 32'h0;
    bus_if.abort     = 1'b0;
    #2;
    chk("rst_trans", 32'(bus_if.trans), 32'd0);
    chk("rst_write", 32'(bus_if.write), 32'd0);
    chk("rst_addr", bus_if.addr, 32'h0);
    chk("rst_wdata", bus_if.wdata, 32'h0);
    chk("rst_size", 32'(bus_if.size), 32'd0);
    chk("rst_prot", 32'(bus_if.prot), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_rsp_abort", 32'(bus_if.rsp_abort), 32'd0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus_if.req_ready), 32'd1);

    // Directed: load, store-then-load, consecutive loads, abort
    tb_mem[32'h10]  = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;
    tb_mem[32'h40]  = 32'hCAFEF00D;
    ref_mem[32'h40] = 32'hCAFEF00D;
    tb_mem[32'h41]  = 32'h0BADF00D;
    ref_mem[32'h41] = 32'h0BADF00D;
    access(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1);
    access(1'b1, 32'h20, 32'h1234, 1'b1, 1'b1, 1'b0);
    access(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(2);
    access(1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0);
    access(1'b0, 32'h31, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1);
    access(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
    access(1'b0, 32'h41, 32'h0, 1'b0, 1'b0, 1'b0);
    access(1'b1, 32'h42, 32'h5555AAAA, 1'b1, 1'b0, 1'b1);
    access(1'b0, 32'h42, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Reset during DATA drops the access
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 32'h10;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b0;
    #1;
    chk("mid_rst_trans", 32'(bus_if.trans), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("mid_rst_addr", bus_if.addr, 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_hold_rsp", 32'(bus_if.rsp_valid), 32'd0);
    n_reset = 1'b1;
    ref_hv  = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rel_rsp", 32'(bus_if.rsp_valid), 32'd0);
    chk("mid_rst_rel_ready", 32'(bus_if.req_ready), 32'd1);
    access(1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic, biased toward consecutive addresses
    prev_a = 32'h11;
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 4 == 0) idle(int'($urandom_range(1, 2)));
      ra = ($urandom % 2 == 1) ? prev_a + 32'd1 : $urandom_range(0, 63);
      access(1'($urandom % 2), ra, $urandom, 1'($urandom % 2), 1'($urandom % 2),
             1'($urandom % 8 == 0));
      prev_a = ra;
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on posedge clk.
REQ-002 SHALL: n_reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: req_valid  input  1  requester has an access pending.
REQ-004 SHALL: req_ready  output  1  unit accepts a request this cycle.
REQ-005 SHALL: req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL: req_addr  input  32  word address.
REQ-007 SHALL: req_wdata  input  32  store data.
REQ-008 SHALL: req_size  input  1  access size, passed through to size.
REQ-009 SHALL: req_priv  input  1  privileged access.
REQ-010 SHALL: rsp_valid  output  1  one-cycle pulse; the access completed.
REQ-011 SHALL: rsp_rdata  output  32  load data; 0 for stores and aborts.
REQ-012 SHALL: rsp_abort  output  1  the access was aborted; valid with rsp_valid.
REQ-013 SHALL: addr, wdata  output  32 each  memory address and store data.
REQ-014 SHALL: rdata  input  32  memory read data.
REQ-015 SHALL: abort  input  1  memory abort.
REQ-016 SHALL: write  output  1  store cycle.
REQ-017 SHALL: size  output  1  access size.
REQ-018 SHALL: prot  output  2  {privileged, data=1}.
REQ-019 SHALL: trans  output  2  00 idle, 01 coprocessor (never driven), 10 nonsequential, 11 sequential.

Function
REQ-020 SHALL: use FSM states IDLE, ADDR and DATA; at most one access outstanding.
REQ-021 SHALL: assert req_ready only in IDLE; an accept is req_valid && req_ready at a clock edge E0.
REQ-022 SHALL: in IDLE, ignore req_valid when req_ready is 0, with no side effects.
REQ-023 SHALL: at E0, register addr, wdata, write=req_write, size, prot, and trans=10 or 11, then enter ADDR.
REQ-024 SHALL: hold all memory outputs stable for the whole ADDR cycle; memory samples them at edge E1.
REQ-025 SHALL: at E1, enter DATA and set trans=00 and write=0, keeping addr/wdata.
REQ-026 SHALL: at E2, capture rdata and abort, pulse rsp_valid for one cycle, and return to IDLE; latency from accept to rsp_valid is 2 cycles.
REQ-027 SHALL: drive rsp_rdata = rdata for a load without abort, and 0 otherwise.
REQ-028 SHALL: set rsp_abort = abort on both loads and stores; a store that aborts is not retried.
REQ-029 SHALL: allow a new accept at E2 (the rsp_valid cycle), giving one access per 3 cycles.
REQ-030 SHALL: outside ADDR, hold trans=00 and write=0.

Reset
REQ-031 SHALL: on n_reset low, immediately drive state=IDLE, trans=00, write=0, size=0, prot=00, addr=0, wdata=0, rsp_valid=0, rsp_abort=0, rsp_rdata=0, req_ready=1 after release, and clear the sequential history.
REQ-032 SHALL: when reset is asserted mid-access (ADDR or DATA), drop the access without producing rsp_valid.

Configuration
REQ-033 SHALL: macro MEMORY_ACCESS_SEQ_EN defined -> drive trans=11 when the accepted access is at E2 of the previous access, has the same req_write, has req_addr == previous addr+1, and the previous access did not abort; otherwise drive 10.
REQ-034 SHALL: MEMORY_ACCESS_SEQ_EN undefined -> always drive trans=10 in ADDR and synthesise no history registers.
REQ-035 SHALL: clear the sequential history on abort, on reset, and on any IDLE cycle without an accept.

Structure
REQ-036 SHALL: put the trans encodings (TRANS_I, TRANS_C, TRANS_N, TRANS_S) and the FSM state enum in shared package limb_pkg.
REQ-037 SHALL: be one flat module with no sub-module.

Verification
REQ-038 SHALL: Load: accept load addr 0x10 (memory[0x10] = 0xDEADBEEF) -> trans=10 for 1 cycle, then rsp_valid with rsp_rdata 0xDEADBEEF 2 cycles after accept.
REQ-039 SHALL: Store then load: store 0x1234 to 0x20, then load 0x20 -> write=1 only in ADDR, and the load returns 0x1234.
REQ-040 SHALL: Sequential: with SEQ_EN, back-to-back loads at 0x30 then 0x31 -> trans 10 then 11; without SEQ_EN -> 10 then 10.
REQ-041 SHALL: Abort: force abort=1 during DATA of a load at 0x40 -> rsp_abort=1, rsp_rdata=0; the next load at 0x41 uses trans=10.
REQ-042 SHALL: Reset mid-access: n_reset low during DATA -> no rsp_valid, trans=00 immediately, and req_ready=1 after release.
